// File: rtl/fc_seq.sv
// Time-multiplexed butterfly bit network: forward majority/XOR pass and backward
// error-spread pass with oscillator-gated weight flips. Optional macro: FC_SEQ_WLOAD_EN.
module fc_seq #(
  parameter int N           = 27,
  parameter int STRIDE_BASE = 3,
  parameter int NUM_LAYERS  = 3,
  localparam int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          oscillator,
  input  logic          fd_prop,
  input  logic          bk_prop,
  input  logic [N-1:0]  fin,
  input  logic [N-1:0]  bin,
`ifdef FC_SEQ_WLOAD_EN
  input  logic          wload_valid,
  input  logic [LW-1:0] wload_layer,
  input  logic [N-1:0]  wload_data,
`endif
  input  logic [LW-1:0] ctrl_rd_layer,
  output logic          busy,
  output logic          fd_prop_done,
  output logic          bk_prop_done,
  output logic [N-1:0]  fout,
  output logic [N-1:0]  bout,
  output logic [N-1:0]  control_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_FDONE = 3'd2,
    S_BWD   = 3'd3,
    S_BDONE = 3'd4
  } state_t;

  localparam logic [LW:0]   NL     = NUM_LAYERS[LW:0];
  localparam logic [LW-1:0] LAST_L = NL[LW-1:0] - 1'b1;

  // (STRIDE_BASE**l) % N, reduced each step so large l cannot overflow.
  function automatic int layer_dist(input int l);
    int d;
    d = 1 % N;
    for (int k = 0; k < l; k++) d = (d * STRIDE_BASE) % N;
    return d;
  endfunction

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  h_q, h_d;
  logic [N-1:0]  e_q, e_d;
  logic [N-1:0]  fout_q, fout_d;
  logic [N-1:0]  bout_q, bout_d;
  logic [N-1:0]  ctrl_q, ctrl_d;
  logic [N-1:0]  w_q [NUM_LAYERS];
  logic [N-1:0]  w_d [NUM_LAYERS];

  logic [N-1:0]  fwd_all [NUM_LAYERS];
  logic [N-1:0]  bwd_all [NUM_LAYERS];
  logic [N-1:0]  fwd_sel, bwd_sel;

  // D==0 needs no special case: MAJ(x,x,x)=x and x|x|x=x.
  for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
    localparam int D = layer_dist(l);
    logic [N-1:0] fwd_l, bwd_l;
    always_comb begin
      fwd_l = '0;
      bwd_l = '0;
      for (int i = 0; i < N; i++) begin
        fwd_l[i] = ((h_q[i] & h_q[(i+N-D)%N]) | (h_q[i] & h_q[(i+D)%N]) |
                    (h_q[(i+N-D)%N] & h_q[(i+D)%N])) ^ w_q[l][i];
        bwd_l[i] = e_q[i] | e_q[(i+N-D)%N] | e_q[(i+D)%N];
      end
    end
    assign fwd_all[l] = fwd_l;
    assign bwd_all[l] = bwd_l;
  end

  assign fwd_sel = fwd_all[cnt_q];
  assign bwd_sel = bwd_all[cnt_q];

  logic          wload_hit;
  logic [LW-1:0] wl_layer;
  logic [N-1:0]  wl_data;
`ifdef FC_SEQ_WLOAD_EN
  assign wload_hit = wload_valid && ({1'b0, wload_layer} < NL);
  assign wl_layer  = wload_layer;
  assign wl_data   = wload_data;
`else
  assign wload_hit = 1'b0;
  assign wl_layer  = '0;
  assign wl_data   = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    e_d     = e_q;
    fout_d  = fout_q;
    bout_d  = bout_q;
    w_d     = w_q;
    ctrl_d  = ({1'b0, ctrl_rd_layer} < NL) ? w_q[ctrl_rd_layer] : '0;
    case (state_q)
      S_IDLE: begin
        // A load and an accepted start on the same edge: the pass sees the new row.
        if (wload_hit) w_d[wl_layer] = wl_data;
        if (fd_prop) begin
          state_d = S_FWD;
          cnt_d   = '0;
          h_d     = fin;
        end else if (bk_prop) begin
          state_d = S_BWD;
          cnt_d   = LAST_L;
          e_d     = bin;
        end
      end
      S_FWD: begin
        h_d = fwd_sel;
        if (cnt_q == LAST_L) begin
          fout_d  = fwd_sel;
          state_d = S_FDONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BWD: begin
        if (oscillator) w_d[cnt_q] = w_q[cnt_q] ^ e_q;
        e_d = bwd_sel;
        if (cnt_q == '0) begin
          bout_d  = bwd_sel;
          state_d = S_BDONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      h_q     <= '0;
      e_q     <= '0;
      fout_q  <= '0;
      bout_q  <= '0;
      ctrl_q  <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) w_q[l] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      e_q     <= e_d;
      fout_q  <= fout_d;
      bout_q  <= bout_d;
      ctrl_q  <= ctrl_d;
      for (int l = 0; l < NUM_LAYERS; l++) w_q[l] <= w_d[l];
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign fd_prop_done = (state_q == S_FDONE);
  assign bk_prop_done = (state_q == S_BDONE);
  assign fout         = fout_q;
  assign bout         = bout_q;
  assign control_out  = ctrl_q;

endmodule

// File: tb/tb_fc_seq.sv
// Directed bench for fc_seq (N=27, 3 layers, tap distances 1/3/9).
module tb_fc_seq;

  localparam int N  = 27;
  localparam int LW = 2;
  localparam logic [N-1:0] ONES = 27'h7FFFFFF;
  // Hand-derived from the layer equations for fin=0 with the weights left by test 3.
  localparam logic [N-1:0] FWD_AFTER_BWD = 27'h1209049;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          oscillator, fd_prop, bk_prop;
  logic [N-1:0]  fin, bin;
  logic [LW-1:0] ctrl_rd_layer;
  logic          busy, fd_prop_done, bk_prop_done;
  logic [N-1:0]  fout, bout, control_out;

  int n_checks = 0;
  int n_fail   = 0;

  fc_seq dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .oscillator    (oscillator),
    .fd_prop       (fd_prop),
    .bk_prop       (bk_prop),
    .fin           (fin),
    .bin           (bin),
`ifdef FC_SEQ_WLOAD_EN
    .wload_valid   (1'b0),
    .wload_layer   (2'd0),
    .wload_data    (27'h0),
`endif
    .ctrl_rd_layer (ctrl_rd_layer),
    .busy          (busy),
    .fd_prop_done  (fd_prop_done),
    .bk_prop_done  (bk_prop_done),
    .fout          (fout),
    .bout          (bout),
    .control_out   (control_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Start a pass, then count cycles to its done pulse (cycle 1 = first cycle after accept).
  task automatic run_pass(input logic fwd, input logic [N-1:0] vec,
                          output int lat, output int busy_n, output int other_n);
    @(negedge clk);
    if (fwd) begin fd_prop = 1'b1; fin = vec; end
    else     begin bk_prop = 1'b1; bin = vec; end
    @(negedge clk);
    fd_prop = 1'b0;
    bk_prop = 1'b0;
    lat = 0; busy_n = 0; other_n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) busy_n++;
      if (fwd ? bk_prop_done : fd_prop_done) other_n++;
      if (fwd ? fd_prop_done : bk_prop_done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [LW-1:0] layer, output logic [N-1:0] v);
    @(negedge clk);
    ctrl_rd_layer = layer;
    @(negedge clk);
    v = control_out;
  endtask

  initial begin
    int lat, busy_n, other_n, fd_cnt, bk_cnt, first;
    logic [N-1:0] v, fout_seen;

    rst_n = 1'b0; oscillator = 1'b0; fd_prop = 1'b0; bk_prop = 1'b0;
    fin = '0; bin = '0; ctrl_rd_layer = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fdone", 32'(fd_prop_done), 32'd0);
    check("rst_bdone", 32'(bk_prop_done), 32'd0);
    check("rst_fout", 32'(fout), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ctrl", 32'(control_out), 32'd0);
    rst_n = 1'b1;

    // 1: isolated bit is voted away
    run_pass(1'b1, 27'h0000001, lat, busy_n, other_n);
    check("t1_lat", 32'(lat), 32'd4);
    check("t1_busy_cycles", 32'(busy_n), 32'd4);
    check("t1_fout", 32'(fout), 32'h0);
    @(negedge clk);
    check("t1_idle_busy", 32'(busy), 32'd0);

    // 2: all-ones / all-zeros pass through zero weights
    run_pass(1'b1, ONES, lat, busy_n, other_n);
    check("t2_ones", 32'(fout), 32'(ONES));
    run_pass(1'b1, 27'h0, lat, busy_n, other_n);
    check("t2_zeros", 32'(fout), 32'h0);

    // 3: backward with flips enabled
    oscillator = 1'b1;
    run_pass(1'b0, 27'h0000001, lat, busy_n, other_n);
    oscillator = 1'b0;
    check("t3_lat", 32'(lat), 32'd4);
    check("t3_no_fdone", 32'(other_n), 32'd0);
    check("t3_bout", 32'(bout), 32'(ONES));
    rd(2'd0, v); check("t3_w0", 32'(v), 32'h1249249);
    rd(2'd1, v); check("t3_w1", 32'(v), 32'h0040201);
    rd(2'd2, v); check("t3_w2", 32'(v), 32'h0000001);
    rd(2'd3, v); check("t3_rd_oob", 32'(v), 32'h0);

    // 4: forward sees the new weights; backward without oscillator leaves them
    run_pass(1'b1, 27'h0, lat, busy_n, other_n);
    check("t4_fout", 32'(fout), 32'(FWD_AFTER_BWD));
    run_pass(1'b0, 27'h0000001, lat, busy_n, other_n);
    check("t4_bout", 32'(bout), 32'(ONES));
    rd(2'd0, v); check("t4_w0", 32'(v), 32'h1249249);
    rd(2'd1, v); check("t4_w1", 32'(v), 32'h0040201);
    rd(2'd2, v); check("t4_w2", 32'(v), 32'h0000001);

    // 5: simultaneous starts, then a start while busy
    @(negedge clk);
    fin = 27'h0; bin = 27'h0000155; fd_prop = 1'b1; bk_prop = 1'b1;
    @(negedge clk);
    fd_prop = 1'b0; bk_prop = 1'b0;
    fd_cnt = 0; bk_cnt = 0; first = 0; fout_seen = '0;
    for (int k = 1; k <= 12; k++) begin
      if (fd_prop_done) begin
        fd_cnt++;
        if (first == 0) begin first = k; fout_seen = fout; end
      end
      if (bk_prop_done) bk_cnt++;
      fd_prop = (k == 2);
      @(negedge clk);
    end
    fd_prop = 1'b0;
    check("t5_fd_count", 32'(fd_cnt), 32'd1);
    check("t5_bk_count", 32'(bk_cnt), 32'd0);
    check("t5_lat", 32'(first), 32'd4);
    check("t5_fout", 32'(fout_seen), 32'(FWD_AFTER_BWD));
    check("t5_bout_held", 32'(bout), 32'(ONES));

    // 6: reset in the middle of a backward pass
    oscillator = 1'b1;
    @(negedge clk);
    bin = 27'h0000001; bk_prop = 1'b1;
    @(negedge clk);
    bk_prop = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_bdone", 32'(bk_prop_done), 32'd0);
    check("t6_fout", 32'(fout), 32'h0);
    check("t6_bout", 32'(bout), 32'h0);
    check("t6_ctrl", 32'(control_out), 32'h0);
    oscillator = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bk_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (bk_prop_done || fd_prop_done || busy) bk_cnt++;
      @(negedge clk);
    end
    check("t6_quiet", 32'(bk_cnt), 32'd0);
    rd(2'd0, v); check("t6_w0", 32'(v), 32'h0);
    rd(2'd1, v); check("t6_w1", 32'(v), 32'h0);
    rd(2'd2, v); check("t6_w2", 32'(v), 32'h0);
    run_pass(1'b1, 27'h0000001, lat, busy_n, other_n);
    check("t6_lat", 32'(lat), 32'd4);
    check("t6_busy_cycles", 32'(busy_n), 32'd4);
    check("t6_fout", 32'(fout), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
